// File: rtl/fifo_frame_pkg.sv
// Shared types and constants for the FIFO frame reader.
package fifo_frame_pkg;

  localparam int unsigned LEN_W      = 16;
  localparam int unsigned SKID_DEPTH = 2;

  typedef enum logic [2:0] {
    IDLE,
    HDR_HI,
    HDR_LO,
    PAYLOAD,
    DROP
  } rd_state_t;

endpackage

// File: rtl/fifo_frame_reader_skid.sv
// rd_skid_buf: two-entry buffer that absorbs the one-cycle FIFO read latency
// and presents payload bytes on a valid/ready interface.
module rd_skid_buf
  import fifo_frame_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [1:0]            occ
);

  logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            occ_q;
  logic                  rd_fire;

  assign rd_valid = (occ_q != 2'd0);
  assign rd_fire  = rd_valid & rd_ready;
  // Head entry is only overwritten after it has been consumed, so data holds while stalled.
  assign rd_data  = mem_q[rd_ptr_q];
  assign occ      = occ_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= wr_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (rd_fire) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      occ_q <= occ_q + {1'b0, wr_en} - {1'b0, rd_fire};
    end
  end

endmodule

// File: rtl/fifo_frame_reader.sv
// Pops length-prefixed frames from the TX byte FIFO and streams the payload with a last flag.
// Optional length checking (oversize/zero -> frame_err + drain) is enabled by FRAME_LEN_CHECK_EN.
module fifo_frame_reader
  import fifo_frame_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned FIFO_ADDR_W   = 6,
  parameter int unsigned MAX_FRAME_LEN = 1518
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]  fifo_dout,
  input  logic                   fifo_empty,
  input  logic [FIFO_ADDR_W:0]   fifo_count,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   frame_err
);

  rd_state_t        state_q, state_d;
  logic [LEN_W-1:0] req_cnt_q, req_cnt_d;
  logic [LEN_W-1:0] out_cnt_q, out_cnt_d;
  logic [7:0]       len_hi_q, len_hi_d;
  logic             inflight_q;
  logic             armed_q;
  logic             rd_req;
  logic             pop;
  logic             accept;
  logic             frame_end;
  logic             skid_wr;
  logic             room;
  logic [1:0]       occ;
  logic [1:0]       occ_after;
  logic [LEN_W-1:0] len;

  assign len        = {len_hi_q, fifo_dout[7:0]};
  assign accept     = m_valid & m_ready;
  assign m_last     = m_valid & (state_q == PAYLOAD) & (out_cnt_q == LEN_W'(1));
  assign frame_end  = accept & m_last;
  assign busy       = (state_q != IDLE);
  assign skid_wr    = inflight_q & (state_q == PAYLOAD);
  // Count the byte leaving this cycle as free space so the stream sustains one byte per cycle.
  assign occ_after  = occ - {1'b0, accept};
  assign room       = (occ_after + {1'b0, inflight_q}) < 2'd2;
  // armed_q keeps the pop request low until the first clock after reset release.
  assign fifo_rd_en = armed_q & ~fifo_empty & rd_req;
  assign pop        = fifo_rd_en;
  assign frame_done = (state_q == PAYLOAD) & frame_end;

  always_comb begin
    rd_req = 1'b0;
    unique case (state_q)
      IDLE, HDR_HI: rd_req = 1'b1;
      // Once the payload is fully requested, only the next LEN_HI may be popped alongside the last byte.
      PAYLOAD:      rd_req = (req_cnt_q != '0) ? room : frame_end;
      DROP:         rd_req = (req_cnt_q != '0);
      default:      rd_req = 1'b0;
    endcase
  end

`ifdef FRAME_LEN_CHECK_EN
  logic frame_err_c;
  assign frame_err = frame_err_c;
`else
  assign frame_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    req_cnt_d = req_cnt_q;
    out_cnt_d = out_cnt_q;
    len_hi_d  = len_hi_q;
`ifdef FRAME_LEN_CHECK_EN
    frame_err_c = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (pop) state_d = HDR_HI;
      end
      HDR_HI: begin
        if (inflight_q) len_hi_d = fifo_dout[7:0];
        if (pop) state_d = HDR_LO;
      end
      HDR_LO: begin
        if (inflight_q) begin
          req_cnt_d = len;
          out_cnt_d = len;
          if (len == '0) begin
            state_d = IDLE;
`ifdef FRAME_LEN_CHECK_EN
            frame_err_c = 1'b1;
          end else if (len > LEN_W'(MAX_FRAME_LEN)) begin
            frame_err_c = 1'b1;
            out_cnt_d   = '0;
            state_d     = DROP;
`endif
          end else begin
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (pop && (req_cnt_q != '0)) req_cnt_d = req_cnt_q - LEN_W'(1);
        if (accept) out_cnt_d = out_cnt_q - LEN_W'(1);
        if (frame_end) state_d = pop ? HDR_HI : IDLE;
      end
      DROP: begin
        if (pop) req_cnt_d = req_cnt_q - LEN_W'(1);
        if (req_cnt_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      req_cnt_q  <= '0;
      out_cnt_q  <= '0;
      len_hi_q   <= '0;
      inflight_q <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_cnt_q  <= req_cnt_d;
      out_cnt_q  <= out_cnt_d;
      len_hi_q   <= len_hi_d;
      inflight_q <= pop;
      armed_q    <= 1'b1;
    end
  end

  rd_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (skid_wr),
    .wr_data  (fifo_dout),
    .rd_ready (m_ready),
    .rd_valid (m_valid),
    .rd_data  (m_data),
    .occ      (occ)
  );

`ifdef FRAME_LEN_CHECK_EN
  logic unused_status;
  assign unused_status = ^fifo_count;
`else
  logic unused_status;
  assign unused_status = ^{fifo_count, 32'(MAX_FRAME_LEN)};
`endif

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Randomized bench for fifo_frame_reader: a queue-based FIFO and frame model predict
// the payload stream, pop counts at each frame end and error pulses.
module tb_fifo_frame_reader;

  localparam int unsigned DW   = 8;
  localparam int unsigned AW   = 6;
  localparam int unsigned MAXL = 1518;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_dout;
  logic          fifo_empty;
  logic [AW:0]   fifo_count;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  logic          busy;
  logic          frame_done;
  logic          frame_err;

  fifo_frame_reader #(
    .DATA_WIDTH    (DW),
    .FIFO_ADDR_W   (AW),
    .MAX_FRAME_LEN (MAXL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_rd_en (fifo_rd_en),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_count (fifo_count),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  byte unsigned fifo_q[$];
  byte unsigned pl_buf[$];
  logic [8:0]   exp_q[$];      // {last, data}
  int           done_mark_q[$];  // cumulative pops expected when each frame completes
  int pops = 0, pushed = 0, exp_err = 0, got_err = 0, cyc = 0;
  int ready_mode = 0, gap_pct = 0, last_acc_cyc = 0;
  bit check_rate = 0, in_frame = 0;
  bit prev_stall = 0, prev_last = 0;
  logic [DW-1:0] prev_data = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic add_frame(input int len);
    bit drop = 0;
    byte unsigned b;
    fifo_q.push_back(8'(len >> 8));
    fifo_q.push_back(8'(len & 255));
`ifdef FRAME_LEN_CHECK_EN
    drop = (len == 0) || (len > int'(MAXL));
    if (drop) exp_err++;
`endif
    for (int i = 0; i < len; i++) begin
      b = (i < pl_buf.size()) ? pl_buf[i] : 8'($urandom);
      fifo_q.push_back(b);
      if (!drop) exp_q.push_back({(i == len - 1), b});
    end
    pushed += 2 + len;
    if (len != 0 && !drop) done_mark_q.push_back(pushed);
    pl_buf.delete();
  endtask

  task automatic drive_inputs();
    bit gap;
    case (ready_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = 1'($urandom_range(0, 1));
      default: m_ready = (cyc % 3 == 0);
    endcase
    gap        = (gap_pct != 0) && ($urandom_range(0, 99) < gap_pct);
    fifo_empty = (fifo_q.size() == 0) || gap;
    fifo_count = 7'((fifo_q.size() > 127) ? 127 : fifo_q.size());
  endtask

  task automatic step();
    bit pop_now, acc;
    logic [8:0] e;
    @(negedge clk);
    cyc++;
    pop_now = fifo_rd_en && !fifo_empty;
    acc     = m_valid && m_ready;
    if (prev_stall) begin
      check("hold_valid", 32'(m_valid), 1);
      check("hold_data", 32'(m_data), 32'(prev_data));
      check("hold_last", 32'(m_last), 32'(prev_last));
    end
    if (frame_done) begin
      check("done_expected", 32'(done_mark_q.size() != 0), 1);
      if (done_mark_q.size() != 0) check("pops_at_done", pops, done_mark_q.pop_front());
      check("done_with_accept", 32'(acc), 1);
    end
    if (acc) begin
      check("byte_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("data", 32'(m_data), 32'(e[7:0]));
        check("last", 32'(m_last), 32'(e[8]));
        check("done_on_last", 32'(frame_done), 32'(e[8]));
        if (check_rate && in_frame) check("rate", cyc - last_acc_cyc, 1);
        in_frame     = !e[8];
        last_acc_cyc = cyc;
      end
    end
    if (frame_err) got_err++;
    if (pop_now) pops++;
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    prev_last  = m_last;
    @(posedge clk);
    #1;
    if (pop_now) fifo_dout = fifo_q.pop_front();
    drive_inputs();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0 || busy) && n < budget) begin
      step();
      n++;
    end
    check("drain_in_budget", 32'(n < budget), 1);
    check("all_popped", pops, pushed);
    check("stream_left", exp_q.size(), 0);
    check("done_left", done_mark_q.size(), 0);
    check("err_count", got_err, exp_err);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rd_en"}, 32'(fifo_rd_en), 0);
    check({tag, "_m_valid"}, 32'(m_valid), 0);
    check({tag, "_m_data"}, 32'(m_data), 0);
    check({tag, "_m_last"}, 32'(m_last), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(frame_done), 0);
    check({tag, "_err"}, 32'(frame_err), 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    fifo_empty = 1'b0;  // non-empty during reset: the pop request must still stay low
    fifo_dout  = '0;
    fifo_count = '0;
    m_ready    = 1'b1;
    #12;
    check_outputs_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    fifo_empty = 1'b1;

    // Single frame, full rate.
    ready_mode = 0; gap_pct = 0; check_rate = 1;
    pl_buf = '{8'hAA, 8'hBB, 8'hCC};
    add_frame(3);
    drain(200);

    // Same frame, downstream ready pattern 1,0,0.
    ready_mode = 2; check_rate = 0;
    pl_buf = '{8'hAA, 8'hBB, 8'hCC};
    add_frame(3);
    drain(200);

    // Back-to-back frames.
    ready_mode = 0; check_rate = 1;
    pl_buf = '{8'h11};
    add_frame(1);
    pl_buf = '{8'h22, 8'h33};
    add_frame(2);
    drain(200);

    // Payload trickles in with FIFO-empty gaps.
    gap_pct = 50; check_rate = 0;
    add_frame(6);
    drain(400);

    // Empty frame followed by a one-byte frame.
    gap_pct = 0; check_rate = 1;
    add_frame(0);
    pl_buf = '{8'h55};
    add_frame(1);
    drain(200);

`ifdef FRAME_LEN_CHECK_EN
    // Oversize frame is drained silently, next frame still flows.
    add_frame(16'h0600);
    add_frame(4);
    drain(5000);
`endif

    // Randomized batches.
    for (int k = 0; k < 8; k++) begin
      ready_mode = $urandom_range(0, 2);
      gap_pct    = (k % 2 == 0) ? 0 : $urandom_range(10, 50);
      check_rate = (ready_mode == 0) && (gap_pct == 0);
      in_frame   = 0;
      for (int f = 0; f < 6; f++) add_frame($urandom_range(0, 40));
      drain(4000);
    end

    // Reset in the middle of a payload.
    ready_mode = 0; gap_pct = 0; check_rate = 0;
    add_frame(20);
    repeat (10) step();
    check("busy_mid_frame", 32'(busy), 1);
    #3;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    fifo_q.delete(); exp_q.delete(); done_mark_q.delete();
    pops = 0; pushed = 0; got_err = 0; exp_err = 0;
    prev_stall = 0; in_frame = 0; fifo_empty = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    check("idle_after_reset", 32'(busy), 0);
    pl_buf = '{8'h5A, 8'hA5};
    add_frame(2);
    drain(200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
